block_stream_writer: RTL and testbench
======================================

Name: block_stream_writer

Overview:
- Command-driven character serializer that generates the keyword stream consumed by the block checker.
- Each accepted command becomes a space-prefixed token: " begin", " end", a single-character word, or a terminating space. Tokens are emitted one byte per transfer.
- Tracks nesting depth and flags unbalanced streams at the source, so testbenches and stimulus generators can produce both legal and illegal block sequences.

Parameters:
- DEPTH_W, 8, width of the nesting-depth counter; depth saturates at 2^DEPTH_W-1.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command (high only in IDLE)
- cmd  input  2  00 BEGIN, 01 END, 10 WORD, 11 FINISH
- cmd_upper  input  1  emit keyword letters in upper case (BEGIN/END only)
- cmd_char  input  8  byte emitted by WORD after its space
- out_valid  output  1  out_char holds a valid byte
- out_ready  input  1  downstream accepts out_char this cycle
- out_char  output  8  emitted byte
- depth  output  DEPTH_W  current nesting depth
- unbalanced  output  1  sticky: an END was issued at depth 0
- overflow  output  1  sticky: a BEGIN was issued at maximum depth
- balanced  output  1  combinational: depth==0 and !unbalanced

Behaviour:
- Clock and reset:
  - One clock domain.
  - reset low asynchronously clears all state: state=IDLE, out_valid=0, out_char=8'h00, index=0, depth=0, unbalanced=0, overflow=0. Hence cmd_ready=1 and balanced=1 during and after reset.
  - Reset mid-token abandons the token. No further bytes of it are emitted, and depth is not updated for it.
- States:
  - IDLE: cmd_ready=1, out_valid=0.
  - EMIT: cmd_ready=0, out_valid=1.
- Acceptance:
  - A command is accepted on the posedge where cmd_valid & cmd_ready.
  - cmd, cmd_upper and cmd_char are latched at acceptance. Later input changes do not affect the token.
- Latency:
  - First byte appears on out_char with out_valid=1 the cycle after acceptance.
- Token contents (index 0 first):
  - BEGIN: 20 62 65 67 69 6E, i.e. " begin".
  - END: 20 65 6E 64, i.e. " end".
  - WORD: 20, cmd_char.
  - FINISH: 20.
- Case rule:
  - With cmd_upper=1, every letter byte of BEGIN/END is emitted with bit 5 cleared (" BEGIN", " END").
  - The space byte and WORD's cmd_char are never modified.
- Transfer and backpressure:
  - A byte transfers on a posedge with out_valid & out_ready.
  - Without transfer, out_char and out_valid hold stable (no byte dropped, no byte repeated).
  - After a transfer, index increments and out_char advances.
  - The transfer of the last byte returns to IDLE. out_valid=0 and cmd_ready=1 the next cycle, so there is one bubble cycle between consecutive tokens.
- Depth update (on the cycle of last-byte transfer only):
  - BEGIN, depth < max: depth+1.
  - BEGIN, depth == max: depth holds, overflow set.
  - END, depth > 0: depth-1.
  - END, depth == 0: depth stays 0, unbalanced set; the token is still emitted in full.
  - WORD and FINISH do not change depth.
- Sticky flags:
  - unbalanced and overflow clear only on reset.
- out_char when idle:
  - Holds the last emitted byte (8'h00 after reset).
- Command ignored in EMIT:
  - cmd_valid asserted while in EMIT has no effect. The command is not lost by the block; the producer must hold it until cmd_ready.

Test Plan:
- Reset then BEGIN, cmd_upper=0, out_ready=1 -> bytes 20 62 65 67 69 6E on 6 consecutive cycles starting the cycle after acceptance; depth 0->1 on the last transfer; balanced=0.
- BEGIN, WORD cmd_char=8'h61, END, FINISH -> stream " begin a end "; final depth=0, unbalanced=0, balanced=1; same stream fed to the block checker gives result=1.
- END from reset -> " end" emitted; unbalanced=1, depth=0, balanced=0. A following BEGIN/END pair leaves unbalanced=1.
- BEGIN with cmd_upper=1, out_ready toggling 1,0,0,1,... -> bytes 20 42 45 47 49 4E, each held stable while out_ready=0; no duplicates.
- DEPTH_W=2: 4 BEGINs -> depth 1,2,3,3 and overflow=1 after the fourth token.
- Reset low after the third byte of an END at depth 2 -> out_valid=0 immediately, depth=0, cmd_ready=1; after release a new BEGIN emits from byte 20.

Source files
------------

// File: rtl/block_stream_writer.sv
// Command-driven keyword serializer: turns BEGIN/END/WORD/FINISH commands into
// space-prefixed byte tokens and tracks block nesting depth at the source.
module block_stream_writer #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd,
  input  logic               cmd_upper,
  input  logic [7:0]         cmd_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_char,
  output logic [DEPTH_W-1:0] depth,
  output logic               unbalanced,
  output logic               overflow,
  output logic               balanced
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam logic [1:0] CMD_BEGIN  = 2'b00;
  localparam logic [1:0] CMD_END    = 2'b01;
  localparam logic [1:0] CMD_WORD   = 2'b10;
  localparam logic [1:0] CMD_FINISH = 2'b11;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

  state_t             state_q, state_d;
  logic [1:0]         cmd_q, cmd_d;
  logic               upper_q, upper_d;
  logic [7:0]         char_q, char_d;
  logic [2:0]         index_q, index_d;
  logic [7:0]         out_char_q, out_char_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               unbal_q, unbal_d;
  logic               ovf_q, ovf_d;

  // Byte at position idx of the token; keyword letters lose bit 5 in upper case.
  function automatic logic [7:0] tokenByte(input logic [1:0] c, input logic up,
                                           input logic [7:0] ch, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h20;
    case (c)
      CMD_BEGIN: begin
        case (idx)
          3'd1:    b = 8'h62;
          3'd2:    b = 8'h65;
          3'd3:    b = 8'h67;
          3'd4:    b = 8'h69;
          3'd5:    b = 8'h6E;
          default: b = 8'h20;
        endcase
      end
      CMD_END: begin
        case (idx)
          3'd1:    b = 8'h65;
          3'd2:    b = 8'h6E;
          3'd3:    b = 8'h64;
          default: b = 8'h20;
        endcase
      end
      CMD_WORD: begin
        if (idx == 3'd1) b = ch;
      end
      default: b = 8'h20;
    endcase
    if (up && (idx != 3'd0) && ((c == CMD_BEGIN) || (c == CMD_END))) b[5] = 1'b0;
    return b;
  endfunction

  function automatic logic [2:0] lastIndex(input logic [1:0] c);
    logic [2:0] l;
    case (c)
      CMD_BEGIN: l = 3'd5;
      CMD_END:   l = 3'd3;
      CMD_WORD:  l = 3'd1;
      default:   l = 3'd0;
    endcase
    return l;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cmd_q      <= CMD_BEGIN;
      upper_q    <= 1'b0;
      char_q     <= 8'h00;
      index_q    <= 3'd0;
      out_char_q <= 8'h00;
      depth_q    <= DEPTH_ZERO;
      unbal_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      upper_q    <= upper_d;
      char_q     <= char_d;
      index_q    <= index_d;
      out_char_q <= out_char_d;
      depth_q    <= depth_d;
      unbal_q    <= unbal_d;
      ovf_q      <= ovf_d;
    end
  end

  // Depth and sticky flags only move on the transfer of a token's last byte.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    upper_d    = upper_q;
    char_d     = char_q;
    index_d    = index_q;
    out_char_d = out_char_q;
    depth_d    = depth_q;
    unbal_d    = unbal_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d    = EMIT;
          cmd_d      = cmd;
          upper_d    = cmd_upper;
          char_d     = cmd_char;
          index_d    = 3'd0;
          out_char_d = 8'h20;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (index_q == lastIndex(cmd_q)) begin
            state_d = IDLE;
            if (cmd_q == CMD_BEGIN) begin
              if (depth_q == DEPTH_MAX) ovf_d = 1'b1;
              else depth_d = depth_q + DEPTH_ONE;
            end else if (cmd_q == CMD_END) begin
              if (depth_q == DEPTH_ZERO) unbal_d = 1'b1;
              else depth_d = depth_q - DEPTH_ONE;
            end
          end else begin
            index_d    = index_q + 3'd1;
            out_char_d = tokenByte(cmd_q, upper_q, char_q, index_q + 3'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign out_valid  = (state_q == EMIT);
  assign out_char   = out_char_q;
  assign depth      = depth_q;
  assign unbalanced = unbal_q;
  assign overflow   = ovf_q;
  assign balanced   = (depth_q == DEPTH_ZERO) && !unbal_q;

endmodule

// File: tb/tb_block_stream_writer.sv
// Directed bench for block_stream_writer: token bytes, latency, backpressure,
// depth tracking, sticky flags, saturation and mid-token reset.
module tb_block_stream_writer;

  localparam int DEPTH_W = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd;
  logic               cmd_upper;
  logic [7:0]         cmd_char;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_char;
  logic [DEPTH_W-1:0] depth;
  logic               unbalanced;
  logic               overflow;
  logic               balanced;

  int vectors     = 0;
  int miscompares = 0;

  block_stream_writer #(.DEPTH_W(DEPTH_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .cmd_upper  (cmd_upper),
    .cmd_char   (cmd_char),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_char   (out_char),
    .depth      (depth),
    .unbalanced (unbalanced),
    .overflow   (overflow),
    .balanced   (balanced)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents a command and returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [1:0] c, input logic up, input logic [7:0] ch);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_upper = up;
    cmd_char  = ch;
    while (!cmd_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("cmd_ready_at_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = ~c;
    cmd_upper = ~up;
    cmd_char  = ~ch;
  endtask

  // Expects n bytes (left-aligned in bytes) on consecutive cycles with out_ready=1.
  task automatic checkToken(input string tag, input logic [47:0] bytes, input int n);
    logic [7:0] last;
    last = 8'h00;
    for (int i = 0; i < n; i++) begin
      last = bytes[47-8*i -: 8];
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_byte"}, 32'(out_char), 32'(last));
      checkOutput({tag, "_busy"}, 32'(cmd_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_bubble_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_bubble_ready"}, 32'(cmd_ready), 32'd1);
    checkOutput({tag, "_hold_char"}, 32'(out_char), 32'(last));
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  localparam logic [47:0] TOK_BEGIN  = 48'h20_62_65_67_69_6E;
  localparam logic [47:0] TOK_END    = 48'h20_65_6E_64_00_00;
  localparam logic [47:0] TOK_UBEGIN = 48'h20_42_45_47_49_4E;
  localparam logic [47:0] TOK_FINISH = 48'h20_00_00_00_00_00;

  initial begin
    int idx;
    int cyc;
    logic [47:0] expBytes;

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    cmd_upper = 1'b0;
    cmd_char  = 8'h00;
    out_ready = 1'b1;

    #12;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_char", 32'(out_char), 32'h00);
    checkOutput("rst_depth", 32'(depth), 32'd0);
    checkOutput("rst_balanced", 32'(balanced), 32'd1);
    checkOutput("rst_unbalanced", 32'(unbalanced), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(2'b00, 1'b0, 8'h00);
    checkToken("begin_lc", TOK_BEGIN, 6);
    checkOutput("begin_lc_depth", 32'(depth), 32'd1);
    checkOutput("begin_lc_balanced", 32'(balanced), 32'd0);

    // A second command held valid during EMIT must not disturb the WORD token.
    applyStimulus(2'b10, 1'b0, 8'h61);
    cmd_valid = 1'b1;
    cmd       = 2'b01;
    checkToken("word_a", 48'h20_61_00_00_00_00, 2);
    cmd_valid = 1'b0;
    checkOutput("word_a_depth", 32'(depth), 32'd1);

    applyStimulus(2'b01, 1'b0, 8'h00);
    checkToken("end_lc", TOK_END, 4);
    checkOutput("end_lc_depth", 32'(depth), 32'd0);

    applyStimulus(2'b11, 1'b0, 8'h00);
    checkToken("finish", TOK_FINISH, 1);
    checkOutput("finish_depth", 32'(depth), 32'd0);
    checkOutput("finish_unbalanced", 32'(unbalanced), 32'd0);
    checkOutput("finish_balanced", 32'(balanced), 32'd1);

    doReset();
    applyStimulus(2'b01, 1'b0, 8'h00);
    checkToken("end_at_zero", TOK_END, 4);
    checkOutput("end_at_zero_unbal", 32'(unbalanced), 32'd1);
    checkOutput("end_at_zero_depth", 32'(depth), 32'd0);
    checkOutput("end_at_zero_balanced", 32'(balanced), 32'd0);
    applyStimulus(2'b00, 1'b0, 8'h00);
    checkToken("pair_begin", TOK_BEGIN, 6);
    checkOutput("pair_begin_depth", 32'(depth), 32'd1);
    applyStimulus(2'b01, 1'b0, 8'h00);
    checkToken("pair_end", TOK_END, 4);
    checkOutput("pair_depth", 32'(depth), 32'd0);
    checkOutput("pair_unbal_sticky", 32'(unbalanced), 32'd1);
    checkOutput("pair_balanced", 32'(balanced), 32'd0);

    doReset();
    applyStimulus(2'b00, 1'b1, 8'h00);
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 40) begin
      out_ready = (cyc % 3 == 0);
      expBytes  = TOK_UBEGIN;
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_byte", 32'(out_char), 32'(expBytes[47-8*idx -: 8]));
      @(posedge clk);
      #1;
      if (out_ready) idx++;
      cyc++;
    end
    out_ready = 1'b1;
    checkOutput("bp_all_bytes", 32'(idx), 32'd6);
    checkOutput("bp_bubble_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_depth", 32'(depth), 32'd1);

    applyStimulus(2'b10, 1'b1, 8'h78);
    checkToken("word_upper", 48'h20_78_00_00_00_00, 2);

    doReset();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(2'b00, 1'b0, 8'h00);
      checkToken("sat_begin", TOK_BEGIN, 6);
      checkOutput("sat_depth", 32'(depth), (k < 4) ? 32'(k) : 32'd3);
      checkOutput("sat_overflow", 32'(overflow), (k == 4) ? 32'd1 : 32'd0);
    end

    doReset();
    applyStimulus(2'b00, 1'b0, 8'h00);
    checkToken("mid_b1", TOK_BEGIN, 6);
    applyStimulus(2'b00, 1'b0, 8'h00);
    checkToken("mid_b2", TOK_BEGIN, 6);
    checkOutput("mid_depth2", 32'(depth), 32'd2);
    applyStimulus(2'b01, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      expBytes = TOK_END;
      checkOutput("mid_end_byte", 32'(out_char), 32'(expBytes[47-8*i -: 8]));
      @(posedge clk);
      #1;
    end
    checkOutput("mid_end_4th", 32'(out_char), 32'h64);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mid_rst_depth", 32'(depth), 32'd0);
    checkOutput("mid_rst_char", 32'(out_char), 32'h00);
    checkOutput("mid_rst_unbal", 32'(unbalanced), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(2'b00, 1'b0, 8'h00);
    checkToken("post_rst_begin", TOK_BEGIN, 6);
    checkOutput("post_rst_depth", 32'(depth), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
